// File: rtl/row_param_sequencer.sv
// Per-scanline perspective parameter sequencer: computes the line-constant scale and
// track row index using one shared restoring divider time-multiplexed over three divisions.
module row_param_sequencer #(
    parameter int DIV_W  = 24,
    parameter int ROW_H  = 80,
    parameter int PY_MIN = 35,
    parameter int PY_MAX = 479
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        line_start,
    input  logic [9:0]  py,
    input  logic [8:0]  y_ball,
    output logic [15:0] scale,
    output logic [10:0] index_y,
    output logic        done,
    output logic        busy,
    output logic        overrun
);

    typedef enum logic [2:0] {
        IDLE, LOAD1, DIV1, LOAD2, DIV2, LOAD3, DIV3, COMMIT
    } state_t;

    localparam int          CW       = $clog2(DIV_W + 1);
    localparam logic [9:0]  PY_LO    = 10'(PY_MIN);
    localparam logic [9:0]  PY_HI    = 10'(PY_MAX);
    localparam logic [9:0]  ROW_H10  = 10'(ROW_H);
    localparam logic [DIV_W-1:0] SCALE_DVD = DIV_W'(480 << 8);

    state_t state, state_nxt;

    logic [CW-1:0]    cnt;
    logic             last_iter;
    logic [9:0]       py_q;
    logic [8:0]       y_q;
    logic [DIV_W-1:0] dvd;
    logic [9:0]       dvs;
    logic [9:0]       rem;
    logic [10:0]      trial;
    logic             q_bit;
    logic [9:0]       rem_nxt;
    logic [15:0]      scale_r;
    logic             inval_r;
    logic             py_ok;
    logic [9:0]       t;
    logic [15:0]      d2_dvd;
    logic [9:0]       sum;
    logic             sum_low;

    assign last_iter = (cnt == CW'(DIV_W - 1));
    assign py_ok     = (py >= PY_LO) && (py <= PY_HI);
    assign t         = 10'd480 - py_q;
    assign d2_dvd    = 16'(t) * 16'd85;
    // In LOAD3 the low bits of dvd hold the depth quotient from the second division.
    assign sum       = 10'(y_q) + 10'(dvd[6:0]);
    assign sum_low   = (sum < ROW_H10);

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        trial   = {rem, dvd[DIV_W-1]};
        q_bit   = (trial >= {1'b0, dvs});
        rem_nxt = q_bit ? 10'(trial - {1'b0, dvs}) : trial[9:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:   if (line_start) state_nxt = py_ok ? LOAD1 : COMMIT;
            LOAD1:  state_nxt = DIV1;
            DIV1:   if (last_iter) state_nxt = LOAD2;
            LOAD2:  state_nxt = DIV2;
            DIV2:   if (last_iter) state_nxt = LOAD3;
            LOAD3:  state_nxt = DIV3;
            DIV3:   if (last_iter) state_nxt = COMMIT;
            COMMIT: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            py_q    <= '0;
            y_q     <= '0;
            dvd     <= '0;
            dvs     <= '0;
            rem     <= '0;
            scale_r <= '0;
            inval_r <= 1'b0;
            scale   <= '0;
            index_y <= '1;
            done    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            done    <= (state == COMMIT);
            overrun <= line_start && (state != IDLE);
            unique case (state)
                IDLE: begin
                    if (line_start) begin
                        py_q    <= py;
                        y_q     <= y_ball;
                        scale_r <= '0;
                        inval_r <= !py_ok;
                    end
                end
                LOAD1: begin
                    dvd <= SCALE_DVD;
                    dvs <= py_q;
                    rem <= '0;
                    cnt <= '0;
                end
                LOAD2: begin
                    scale_r <= dvd[15:0];
                    dvd     <= DIV_W'(d2_dvd);
                    dvs     <= 10'd450;
                    rem     <= '0;
                    cnt     <= '0;
                end
                LOAD3: begin
                    // Below one row height the third division still runs, on a zero dividend.
                    inval_r <= sum_low;
                    dvd     <= sum_low ? '0 : DIV_W'(sum - ROW_H10);
                    dvs     <= ROW_H10;
                    rem     <= '0;
                    cnt     <= '0;
                end
                DIV1, DIV2, DIV3: begin
                    dvd <= {dvd[DIV_W-2:0], q_bit};
                    rem <= rem_nxt;
                    cnt <= cnt + 1'b1;
                end
                COMMIT: begin
                    scale   <= scale_r;
                    index_y <= inval_r ? 11'h7FF : dvd[10:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_row_param_sequencer.sv
// Directed bench for row_param_sequencer: hand-computed scale/index/latency vectors,
// overrun, back-to-back acceptance and mid-operation reset.
module tb_row_param_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        line_start = 1'b0;
    logic [9:0]  py = '0;
    logic [8:0]  y_ball = '0;
    logic [15:0] scale;
    logic [10:0] index_y;
    logic        done;
    logic        busy;
    logic        overrun;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    row_param_sequencer #(.DIV_W(24), .ROW_H(80), .PY_MIN(35), .PY_MAX(479)) dut (
        .clk(clk), .rst_n(rst_n), .line_start(line_start), .py(py), .y_ball(y_ball),
        .scale(scale), .index_y(index_y), .done(done), .busy(busy), .overrun(overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive a request sampled by the next rising edge (cycle 0); return at the negedge of cycle 1.
    task automatic issue(input logic [9:0] p, input logic [8:0] y);
        @(negedge clk);
        line_start = 1'b1;
        py = p;
        y_ball = y;
        @(negedge clk);
        line_start = 1'b0;
    endtask

    // Starting at the negedge of cycle k0, wait for done; returns cycle of done (200 = timeout).
    task automatic wait_done(input int k0, output int k);
        k = k0;
        while (!done && k < 200) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic run_req(input string tag, input logic [9:0] p, input logic [8:0] y,
                           input logic [15:0] e_scale, input logic [10:0] e_idx, input int e_lat);
        int k;
        issue(p, y);
        wait_done(1, k);
        check({tag, "_lat"}, k, e_lat);
        check({tag, "_scale"}, scale, e_scale);
        check({tag, "_idx"}, index_y, e_idx);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        int k;
        int seen;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rst_scale", scale, 0);
        check("rst_idx", index_y, 11'h7FF);
        check("rst_busy", busy, 0);
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done || overrun) seen++;
        end
        check("idle_no_done", seen, 0);

        run_req("py240", 10'd240, 9'd200, 16'd512, 11'd2, 77);
        run_req("py35", 10'd35, 9'd80, 16'd3510, 11'd1, 77);
        run_req("py479", 10'd479, 9'd100, 16'd256, 11'd0, 77);
        run_req("sumlow", 10'd479, 9'd50, 16'd256, 11'h7FF, 77);
        run_req("py100", 10'd100, 9'd300, 16'd1228, 11'd3, 77);
        run_req("py20", 10'd20, 9'd200, 16'd0, 11'h7FF, 2);
        run_req("py500", 10'd500, 9'd200, 16'd0, 11'h7FF, 2);
        run_req("py34", 10'd34, 9'd200, 16'd0, 11'h7FF, 2);

        // Overrun during a py=240 request, then a new request accepted in the done cycle.
        issue(10'd240, 9'd200);
        k = 1;
        while (k < 40) begin @(negedge clk); k++; end
        check("ovr_busy40", busy, 1);
        line_start = 1'b1;
        py = 10'd100;
        y_ball = 9'd300;
        @(negedge clk); k++;
        line_start = 1'b0;
        check("ovr_pulse41", overrun, 1);
        @(negedge clk); k++;
        check("ovr_clear42", overrun, 0);
        while (k < 76) begin @(negedge clk); k++; end
        check("ovr_busy76", busy, 1);
        check("ovr_nodone76", done, 0);
        @(negedge clk); k++;
        check("ovr_done77", done, 1);
        check("ovr_scale", scale, 512);
        check("ovr_idx", index_y, 2);
        check("ovr_nopulse77", overrun, 0);
        line_start = 1'b1;
        py = 10'd35;
        y_ball = 9'd80;
        @(negedge clk); k++;
        line_start = 1'b0;
        check("b2b_noovr", overrun, 0);
        check("b2b_busy", busy, 1);
        wait_done(k, k);
        check("b2b_lat", k, 154);
        check("b2b_scale", scale, 3510);
        check("b2b_idx", index_y, 1);

        // Reset in the middle of a request discards it.
        issue(10'd100, 9'd300);
        k = 1;
        while (k < 30) begin @(negedge clk); k++; end
        rst_n = 1'b0;
        #1;
        check("mrst_scale", scale, 0);
        check("mrst_idx", index_y, 11'h7FF);
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        check("mrst_quiet", seen, 0);
        run_req("post_rst", 10'd240, 9'd200, 16'd512, 11'd2, 77);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
